// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access frame engine.
package spi_reg_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 7;
  localparam int CMD_RD_BIT = 7;
  localparam logic [DATA_W-1:0] RD_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_WR_DATA,
    ST_RD_DATA
  } state_t;

  // Address 0 is the ID register and everything past the bank is unmapped.
  function automatic logic addr_in_bank(input logic [ADDR_W-1:0] a, input int nregs);
    return (a != '0) && (int'(a) < nregs);
  endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// NREGS x 8 register storage: write port, combinational read mux, flat image.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int               NREGS    = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 8'hA5
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [DATA_W-1:0]       rdata,
  output logic [NREGS*DATA_W-1:0] regs_q
);

  localparam int IDX_W = $clog2(NREGS);

  logic [DATA_W-1:0] mem [NREGS];

  // Callers only raise we for addresses inside 1..NREGS-1.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = RD_DEFAULT;
    if (raddr == '0)
      rdata = ID_VALUE;
    else if (int'(raddr) < NREGS)
      rdata = mem[raddr[IDX_W-1:0]];
  end

  always_comb begin
    regs_q = '0;
    for (int i = 0; i < NREGS; i++)
      regs_q[i*DATA_W +: DATA_W] = (i == 0) ? ID_VALUE : mem[i];
  end

endmodule

// File: rtl/spi_reg_frame.sv
// Command/address/data frame decoder in the SPI clock domain with MISO byte staging.
module spi_reg_frame
  import spi_reg_pkg::*;
#(
  parameter int                NREGS    = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 8'hA5
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    cs_n,
  input  logic                    rx_valid,
  input  logic [DATA_W-1:0]       rx_data,
  output logic [DATA_W-1:0]       tx_data,
  output logic [NREGS*DATA_W-1:0] regs_q,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic                    wr_toggle
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;

  // 7-bit increment wraps 127 -> 0 naturally.
  assign addr_nxt = addr + 7'd1;
  assign rd_addr  = (state == ST_CMD) ? rx_data[ADDR_W-1:0] : addr_nxt;
  assign wr_en    = rx_valid && !cs_n && (state == ST_WR_DATA) && addr_in_bank(addr, NREGS);

  spi_reg_bank #(
    .NREGS    (NREGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .sclk   (sclk),
    .rst    (rst),
    .we     (wr_en),
    .waddr  (addr),
    .wdata  (rx_data),
    .raddr  (rd_addr),
    .rdata  (rd_data),
    .regs_q (regs_q)
  );

  // Frame state: cleared by rst or by cs_n going high, independently of sclk.
  always_ff @(posedge sclk or posedge rst or posedge cs_n) begin
    if (rst) begin
      state   <= ST_CMD;
      addr    <= '0;
      tx_data <= ID_VALUE;
    end else if (cs_n) begin
      state   <= ST_CMD;
      addr    <= '0;
      tx_data <= ID_VALUE;
    end else if (rx_valid) begin
      case (state)
        ST_CMD: begin
          addr <= rx_data[ADDR_W-1:0];
          if (rx_data[CMD_RD_BIT]) begin
            state   <= ST_RD_DATA;
            tx_data <= rd_data;
          end else begin
            state   <= ST_WR_DATA;
            tx_data <= ID_VALUE;
          end
        end
        ST_WR_DATA: addr <= addr_nxt;
        ST_RD_DATA: begin
          addr    <= addr_nxt;
          tx_data <= rd_data;
        end
        default: state <= ST_CMD;
      endcase
    end
  end

  // Write-event export survives cs_n so the system side sees every accepted write.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wr_addr   <= '0;
      wr_toggle <= 1'b0;
    end else if (wr_en) begin
      wr_addr   <= addr;
      wr_toggle <= ~wr_toggle;
    end
  end

endmodule

// File: tb/tb_spi_reg_frame.sv
// Self-checking bench for spi_reg_frame against a byte-index frame model.
module tb_spi_reg_frame;

  localparam int NREGS = 16;
  localparam logic [7:0] ID = 8'hA5;

  logic             sclk = 1'b0;
  logic             rst;
  logic             cs_n;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic [7:0]       tx_data;
  logic [NREGS*8-1:0] regs_q;
  logic [6:0]       wr_addr;
  logic             wr_toggle;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_regs [NREGS];
  logic       m_toggle;
  logic [6:0] m_wr_addr;
  logic [6:0] m_base;
  logic       m_rd;

  logic [7:0] fb      [16];
  logic [7:0] obs_tx  [16];
  logic [7:0] exp_tx  [16];
  logic       obs_tog [16];
  logic       exp_tog [16];
  logic [6:0] obs_wa  [16];
  logic [6:0] exp_wa  [16];
  logic [NREGS*8-1:0] obs_img, exp_img;

  spi_reg_frame #(.NREGS(NREGS), .ID_VALUE(ID)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .cs_n      (cs_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .regs_q    (regs_q),
    .wr_addr   (wr_addr),
    .wr_toggle (wr_toggle)
  );

  always #5 sclk = ~sclk;

  function automatic logic [7:0] m_read(input int a);
    if (a == 0) return ID;
    if (a >= NREGS) return 8'h00;
    return m_regs[a];
  endfunction

  function automatic logic [NREGS*8-1:0] m_image();
    logic [NREGS*8-1:0] img;
    for (int i = 0; i < NREGS; i++) img[i*8 +: 8] = (i == 0) ? ID : m_regs[i];
    return img;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_toggle  = 1'b0;
    m_wr_addr = 7'd0;
  endtask

  // One byte time: tx is captured before the byte completes, outputs just after.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] seen,
                           output logic tog, output logic [6:0] wa);
    @(negedge sclk);
    seen     = tx_data;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge sclk);
    rx_valid = 1'b0;
    tog      = wr_toggle;
    wa       = wr_addr;
    rx_data  = 8'($urandom);
    repeat (6) @(negedge sclk);
  endtask

  task automatic run_frame(input int n);
    logic [7:0] seen;
    logic       tog;
    logic [6:0] wa;
    int         a;
    @(negedge sclk);
    cs_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == 0)     exp_tx[k] = ID;
      else if (m_rd)  exp_tx[k] = m_read((int'(m_base) + k - 1) % 128);
      else            exp_tx[k] = ID;
      send_byte(fb[k], seen, tog, wa);
      obs_tx[k] = seen; obs_tog[k] = tog; obs_wa[k] = wa;
      if (k == 0) begin
        m_base = fb[0][6:0];
        m_rd   = fb[0][7];
      end else if (!m_rd) begin
        a = (int'(m_base) + k - 1) % 128;
        if (a >= 1 && a < NREGS) begin
          m_regs[a] = fb[k];
          m_toggle  = ~m_toggle;
          m_wr_addr = 7'(a);
        end
      end
      exp_tog[k] = m_toggle;
      exp_wa[k]  = m_wr_addr;
    end
    obs_img = regs_q;
    exp_img = m_image();
    @(negedge sclk);
    cs_n = 1'b1;
    repeat (2) @(negedge sclk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    m_reset();
    repeat (3) @(negedge sclk);
    checks++; if (tx_data !== ID) begin errors++; $display("FAIL reset_tx: got %h expected %h", tx_data, ID); end
    checks++; if (regs_q !== m_image()) begin errors++; $display("FAIL reset_regs: got %h expected %h", regs_q, m_image()); end
    checks++; if (wr_toggle !== 1'b0) begin errors++; $display("FAIL reset_toggle: got %b expected 0", wr_toggle); end
    checks++; if (wr_addr !== 7'd0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    rst = 1'b0;
    repeat (2) @(negedge sclk);
    checks++; if (tx_data !== ID) begin errors++; $display("FAIL idle_tx: got %h expected %h", tx_data, ID); end
  endtask

  task automatic test_write();
    fb[0] = 8'h03; fb[1] = 8'h11; fb[2] = 8'h22;
    run_frame(3);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_tog[k] !== exp_tog[k]) begin errors++; $display("FAIL write_toggle[%0d]: got %b expected %b", k, obs_tog[k], exp_tog[k]); end
      checks++; if (obs_wa[k] !== exp_wa[k]) begin errors++; $display("FAIL write_wr_addr[%0d]: got %h expected %h", k, obs_wa[k], exp_wa[k]); end
    end
    checks++; if (obs_img[3*8 +: 8] !== 8'h11) begin errors++; $display("FAIL write_reg3: got %h expected 11", obs_img[3*8 +: 8]); end
    checks++; if (obs_img[4*8 +: 8] !== 8'h22) begin errors++; $display("FAIL write_reg4: got %h expected 22", obs_img[4*8 +: 8]); end
    checks++; if (obs_tog[1] !== 1'b1 || wr_toggle !== 1'b0) begin errors++; $display("FAIL write_two_flips: got %b,%b expected 1,0", obs_tog[1], wr_toggle); end
    checks++; if (wr_addr !== 7'd4) begin errors++; $display("FAIL write_last_addr: got %h expected 4", wr_addr); end
    checks++; if (obs_img !== exp_img) begin errors++; $display("FAIL write_image: got %h expected %h", obs_img, exp_img); end
  endtask

  task automatic test_read();
    fb[0] = 8'h83; fb[1] = 8'h00; fb[2] = 8'h00;
    run_frame(3);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_tx[k] !== exp_tx[k]) begin errors++; $display("FAIL read_tx[%0d]: got %h expected %h", k, obs_tx[k], exp_tx[k]); end
    end
    checks++; if (obs_tx[1] !== 8'h11 || obs_tx[2] !== 8'h22) begin errors++; $display("FAIL read_seq: got %h %h expected 11 22", obs_tx[1], obs_tx[2]); end
  endtask

  task automatic test_top_bound();
    logic t0;
    t0 = wr_toggle;
    fb[0] = 8'h0F; fb[1] = 8'h77; fb[2] = 8'h88; fb[3] = 8'h99;
    run_frame(4);
    checks++; if (obs_img !== exp_img) begin errors++; $display("FAIL bound_image: got %h expected %h", obs_img, exp_img); end
    checks++; if (obs_img[15*8 +: 8] !== 8'h77) begin errors++; $display("FAIL bound_reg15: got %h expected 77", obs_img[15*8 +: 8]); end
    checks++; if (wr_toggle !== ~t0 || wr_addr !== 7'd15) begin errors++; $display("FAIL bound_one_toggle: got %b/%h expected %b/0f", wr_toggle, wr_addr, ~t0); end
    fb[0] = 8'h8F; fb[1] = 8'h00; fb[2] = 8'h00;
    run_frame(3);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_tx[k] !== exp_tx[k]) begin errors++; $display("FAIL bound_read_tx[%0d]: got %h expected %h", k, obs_tx[k], exp_tx[k]); end
    end
    checks++; if (obs_tx[1] !== 8'h77 || obs_tx[2] !== 8'h00) begin errors++; $display("FAIL bound_read_seq: got %h %h expected 77 00", obs_tx[1], obs_tx[2]); end
  endtask

  task automatic test_addr0_and_wrap();
    logic t0;
    logic [6:0] a0;
    t0 = wr_toggle; a0 = wr_addr;
    fb[0] = 8'h00; fb[1] = 8'h55;
    run_frame(2);
    checks++; if (obs_img[7:0] !== ID) begin errors++; $display("FAIL addr0_reg0: got %h expected %h", obs_img[7:0], ID); end
    checks++; if (wr_toggle !== t0 || wr_addr !== a0) begin errors++; $display("FAIL addr0_no_event: got %b/%h expected %b/%h", wr_toggle, wr_addr, t0, a0); end
    fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h00;
    run_frame(3);
    checks++; if (obs_tx[1] !== 8'h00 || obs_tx[2] !== ID) begin errors++; $display("FAIL wrap_seq: got %h %h expected 00 %h", obs_tx[1], obs_tx[2], ID); end
  endtask

  task automatic test_partial_byte();
    logic [7:0] seen;
    logic       tog;
    logic [6:0] wa;
    fb[0] = 8'h05; fb[1] = 8'h5A;
    run_frame(2);
    @(negedge sclk);
    cs_n = 1'b0;
    send_byte(8'h05, seen, tog, wa);
    repeat (4) @(negedge sclk);
    cs_n = 1'b1;
    repeat (2) @(negedge sclk);
    checks++; if (regs_q !== m_image() || wr_toggle !== m_toggle) begin errors++; $display("FAIL partial_no_write: got %h/%b expected %h/%b", regs_q, wr_toggle, m_image(), m_toggle); end
    fb[0] = 8'h85; fb[1] = 8'h00; fb[2] = 8'($urandom);
    run_frame(3);
    for (int k = 0; k < 3; k++) begin
      checks++; if (obs_tx[k] !== exp_tx[k]) begin errors++; $display("FAIL partial_new_frame_tx[%0d]: got %h expected %h", k, obs_tx[k], exp_tx[k]); end
    end
    checks++; if (obs_tx[1] !== 8'h5A) begin errors++; $display("FAIL partial_reg5: got %h expected 5a", obs_tx[1]); end
  endtask

  task automatic test_cs_async();
    logic [7:0] seen;
    logic       tog;
    logic [6:0] wa;
    @(negedge sclk);
    cs_n = 1'b0;
    send_byte(8'h83, seen, tog, wa);
    checks++; if (tx_data !== m_read(3)) begin errors++; $display("FAIL cs_pre_tx: got %h expected %h", tx_data, m_read(3)); end
    #2 cs_n = 1'b1;
    #1;
    checks++; if (tx_data !== ID) begin errors++; $display("FAIL cs_async_tx: got %h expected %h", tx_data, ID); end
    checks++; if (regs_q !== m_image() || wr_toggle !== m_toggle || wr_addr !== m_wr_addr) begin errors++; $display("FAIL cs_hold_state: got %h/%b/%h expected %h/%b/%h", regs_q, wr_toggle, wr_addr, m_image(), m_toggle, m_wr_addr); end
    repeat (2) @(negedge sclk);
  endtask

  task automatic test_random();
    int n;
    int a;
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 6);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, NREGS + 2);
      fb[0] = {1'($urandom_range(0, 1)), 7'(a)};
      for (int k = 1; k < n; k++) fb[k] = 8'($urandom);
      run_frame(n);
      for (int k = 0; k < n; k++) begin
        checks++; if (obs_tx[k] !== exp_tx[k]) begin errors++; $display("FAIL rand%0d_tx[%0d]: cmd %h got %h expected %h", it, k, fb[0], obs_tx[k], exp_tx[k]); end
        checks++; if (obs_tog[k] !== exp_tog[k] || obs_wa[k] !== exp_wa[k]) begin errors++; $display("FAIL rand%0d_event[%0d]: got %b/%h expected %b/%h", it, k, obs_tog[k], obs_wa[k], exp_tog[k], exp_wa[k]); end
      end
      checks++; if (obs_img !== exp_img) begin errors++; $display("FAIL rand%0d_image: got %h expected %h", it, obs_img, exp_img); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seen;
    logic       tog;
    logic [6:0] wa;
    fb[0] = 8'h01; fb[1] = 8'hAA; fb[2] = 8'hBB;
    run_frame(3);
    @(negedge sclk);
    cs_n = 1'b0;
    send_byte(8'h05, seen, tog, wa);
    #2 rst = 1'b1;
    #1;
    m_reset();
    checks++; if (regs_q !== m_image()) begin errors++; $display("FAIL rst_mid_regs: got %h expected %h", regs_q, m_image()); end
    checks++; if (tx_data !== ID || wr_toggle !== 1'b0 || wr_addr !== 7'd0) begin errors++; $display("FAIL rst_mid_ctrl: got %h/%b/%h expected %h/0/00", tx_data, wr_toggle, wr_addr, ID); end
    @(negedge sclk);
    rst = 1'b0;
    cs_n = 1'b1;
    repeat (2) @(negedge sclk);
    fb[0] = 8'h81; fb[1] = 8'h00;
    run_frame(2);
    checks++; if (obs_tx[0] !== ID || obs_tx[1] !== 8'h00) begin errors++; $display("FAIL rst_mid_reread: got %h %h expected %h 00", obs_tx[0], obs_tx[1], ID); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_top_bound();
    test_addr0_and_wrap();
    test_partial_byte();
    test_cs_async();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_frame.md
# spi_reg_frame

Byte-level register-access protocol engine clocked in the SPI clock domain. It sits directly downstream of the SPI shift register. It consumes each completed MOSI byte, decodes a command/address/data frame, and updates a small register bank. It also presents the next MISO byte for the shift register to load at the following byte boundary. Register contents and a write-event toggle are exported for synchronisation into the system clock domain by a separate synchroniser.

## Interface
Parameters:
- NREGS, 16, number of 8-bit registers (2..128); address 0 is the read-only ID register.
- ID_VALUE, 8'hA5, constant returned when reading address 0 and driven on tx_data while idle.

Ports:
- sclk  in  1  SPI clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high; clears all state, including registers.
- cs_n  in  1  chip select, active low; high asynchronously clears frame state only (FSM, address), not registers.
- rx_valid  in  1  one-sclk pulse: rx_data holds a completed MOSI byte.
- rx_data  in  8  received byte, MSB first on the wire.
- tx_data  out  8  byte to be loaded by the shift register at the next byte boundary.
- regs_q  out  NREGS*8  flat register image; reg i at [8i+7:8i]; slot 0 reads ID_VALUE.
- wr_addr  out  7  address of the most recent accepted write.
- wr_toggle  out  1  flips once per accepted register write (CDC event).

## Operation
- FSM states: CMD, WR_DATA, RD_DATA. Reset and cs_n high force CMD.
- CMD + rx_valid: decode rx_data[7] (1 = read, 0 = write) and load the address counter from rx_data[6:0].
  - Read: go to RD_DATA; tx_data <= data at that address.
  - Write: go to WR_DATA; tx_data <= ID_VALUE.
- WR_DATA + rx_valid: write rx_data to reg[addr] if 1 <= addr < NREGS; if written, wr_addr <= addr and wr_toggle flips. Then addr increments.
- RD_DATA + rx_valid: addr increments; tx_data <= data at (addr+1).
- Read data rule: addr 0 returns ID_VALUE; addr >= NREGS returns 8'h00; otherwise the register value.
- Address counter is 7 bits and wraps 127 -> 0 (reads after the wrap return ID_VALUE first).
- Writes to addr 0 or addr >= NREGS are dropped silently: no toggle, no wr_addr change.
- A frame ends only on cs_n high. Any number of data bytes per frame is legal. A partial byte before cs_n high produces no rx_valid, so it has no effect.
- Data is 8 bits fixed; there are no arithmetic side effects beyond the address increment.

## Timing
- Reset values:
  - tx_data = ID_VALUE, regs (1..NREGS-1) = 8'h00, wr_addr = 0, wr_toggle = 0, state = CMD, addr = 0.
- cs_n high: state = CMD and tx_data = ID_VALUE asynchronously; regs, wr_addr and wr_toggle are held.
- tx_data is registered and updates on the same posedge that samples rx_valid. It is stable for at least half an sclk before the shift register loads it on the following negedge.
- Register write latency: regs_q and wr_toggle change on the posedge sampling the data byte's rx_valid.
- First read data appears in the byte after the command; the byte clocked out during the command is ID_VALUE.
- rst asserted mid-frame: immediate clear; the next frame must start with a command byte.
- rx_valid is never asserted on two consecutive sclk posedges (minimum byte length is 8 sclk); no back-pressure exists.

## Structure
- Shared package spi_reg_pkg holds:
  - the state enum;
  - DATA_W = 8 and ADDR_W = 7;
  - CMD_RD_BIT = 7;
  - the read-default constant 8'h00.
- One natural sub-module, spi_reg_bank: NREGS x 8 storage with write port, combinational read mux and flat regs_q output. The FSM, address counter and tx_data register stay in the top.

## Test plan
- Reset, no activity: tx_data = 8'hA5, regs_q all zero except slot 0 = 8'hA5, wr_toggle = 0.
- Write frame 8'h03, 8'h11, 8'h22: reg3 = 8'h11, reg4 = 8'h22, wr_toggle flips twice, wr_addr = 4.
- Read frame 8'h83 then 2 dummy bytes: tx_data sequence A5, 11, 22.
- Write 8'h0F, 8'h77, 8'h88, 8'h99 with NREGS = 16:
  - reg15 = 8'h77; 8'h88 and 8'h99 (addr 16, 17) are dropped, with one toggle only.
  - Read 8'h8F plus 2 dummy bytes: tx_data sequence 8'h77, 8'h00.
- Write 8'h00, 8'h55: reg0 is unchanged; wr_toggle does not flip. Read from 8'hFF plus 2 dummies: tx_data sequence 8'h00, then 8'hA5 (wrap to addr 0).
- cs_n high after 4 bits of a data byte, then new frame 8'h85, 8'h00, 8'hXX:
  - no write from the partial byte;
  - the new frame decodes 8'h85 as a command and returns reg5.
  - rst pulse mid-frame clears all registers to zero.
